// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roller.
//   face_t     : 3-bit dice face, 0..7 encodes faces 1..8
//   state_t    : roller FSM states
//   LFSR_SEED  : LFSR value after reset
//   LFSR_TAPS  : feedback mask for x^8+x^6+x^5+x^4+1 (shift-left Fibonacci)
//   lfsr_next  : one Fibonacci LFSR step
package dice_pkg;

  typedef logic [2:0] face_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIN   = 2'd1,
    TUMBLE = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Shift left and feed the XOR of the tapped bits into bit 0. The
  // polynomial is maximal, so a non-zero seed never reaches all-zero.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dice_roller_if.sv
// Button-in / face-out bundle of the dice roller.
//   btn_n   : raw push button, 0 = pressed
//   value   : current face, feeds eight_dice.s
//   rolling : high while the face is spinning or tumbling
//   done    : one-cycle pulse when the face settles
// master = the roller, slave = the button source / display consumer.
interface dice_roller_if;
  import dice_pkg::*;

  logic  btn_n;
  face_t value;
  logic  rolling;
  logic  done;

  modport master (input btn_n, output value, output rolling, output done);
  modport slave  (output btn_n, input value, input rolling, input done);
endinterface

// File: rtl/switch_debouncer.sv
// Synchronizes and debounces an active-low, bouncing push button.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   in_n    : raw asynchronous button, 0 = pressed
//   pressed : debounced level, 1 = pressed
// The level is inverted before the synchronizer so both flops reset to
// "not pressed". A new level is accepted only after it has differed from
// the accepted level for DEBOUNCE_CYCLES consecutive cycles.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic in_n,
  output logic pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    sync1_d   = ~in_n;
    sync2_d   = sync1_q;
    cnt_d     = '0;
    pressed_d = pressed_q;
    if (sync2_q != pressed_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        pressed_d = ~pressed_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  assign pressed = pressed_q;

endmodule

// File: rtl/dice_roller.sv
// Dice roller: button in, settled dice face out.
//   clk : system clock (50 MHz)
//   rst : synchronous active-high reset
//   bus : dice_roller_if.master (btn_n in; value, rolling, done out)
// Holding the button spins the face once per TICK_DIV cycles; releasing it
// tumbles through TUMBLE_STEPS LFSR faces at intervals TICK_DIV*k, k=1..N,
// then settles and pulses done. All outputs are registered.
module dice_roller
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 2500000,
  parameter int TUMBLE_STEPS    = 8
) (
  input  logic          clk,
  input  logic          rst,
  dice_roller_if.master bus
);

  localparam int TIMER_W = $clog2(TICK_DIV * TUMBLE_STEPS + 1);
  localparam int K_W     = $clog2(TUMBLE_STEPS + 1);

  logic pressed_db;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst    (rst),
    .in_n   (bus.btn_n),
    .pressed(pressed_db)
  );

  state_t             state_q, state_d;
  face_t              value_q, value_d;
  logic               rolling_q, rolling_d;
  logic               done_q, done_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [K_W-1:0]     k_q, k_d;
  logic               prev_q, prev_d;

  logic press_rise, press_fall, step;
  int   interval;

  assign press_rise = pressed_db & ~prev_q;
  assign press_fall = ~pressed_db & prev_q;

  // Step interval is TICK_DIV while spinning and grows linearly with k while
  // tumbling, giving the slowing cadence.
  always_comb begin
    interval = (state_q == TUMBLE) ? TICK_DIV * int'(k_q) : TICK_DIV;
    step     = (int'(timer_q) == interval - 1);
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    timer_d = timer_q;
    k_d     = k_q;
    done_d  = 1'b0;
    lfsr_d  = lfsr_next(lfsr_q);
    prev_d  = pressed_db;

    unique case (state_q)
      IDLE: begin
        if (press_rise) begin
          state_d = SPIN;
          timer_d = '0;
        end
      end
      SPIN: begin
        if (press_fall) begin
          state_d = TUMBLE;
          k_d     = K_W'(1);
          timer_d = '0;
        end else if (step) begin
          value_d = value_q + face_t'(1);
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      TUMBLE: begin
        // A new press restarts the spin from the current face; no done.
        if (press_rise) begin
          state_d = SPIN;
          k_d     = '0;
          timer_d = '0;
        end else if (step) begin
          value_d = lfsr_q[2:0];
          timer_d = '0;
          if (k_q == K_W'(TUMBLE_STEPS)) begin
            state_d = IDLE;
            k_d     = '0;
            done_d  = 1'b1;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Derived from the next state so rolling is already low alongside done.
    rolling_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      value_q   <= '0;
      rolling_q <= 1'b0;
      done_q    <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      timer_q   <= '0;
      k_q       <= '0;
      prev_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      rolling_q <= rolling_d;
      done_q    <= done_d;
      lfsr_q    <= lfsr_d;
      timer_q   <= timer_d;
      k_q       <= k_d;
      prev_q    <= prev_d;
    end
  end

  assign bus.value   = value_q;
  assign bus.rolling = rolling_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_dice_roller.sv
// Directed self-checking bench for dice_roller with DEBOUNCE_CYCLES=4,
// TICK_DIV=3, TUMBLE_STEPS=2. Edge numbers in comments count posedges
// since the button input last changed (E, G) within each phase.
module tb_dice_roller;
  import dice_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [7:0] m_lfsr;
  logic [2:0] exp1, exp2, exp3, start;

  dice_roller_if dbus ();

  dice_roller #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV       (3),
    .TUMBLE_STEPS   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dbus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, free-running.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {3'b000, dbus.rolling, dbus.done, dbus.value};
  endfunction

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    dbus.btn_n = 1'b1;

    // Reset
    tick(2);
    check("rst_value", 8'(dbus.value), 8'd0);
    check("rst_rolling", 8'(dbus.rolling), 8'd0);
    check("rst_done", 8'(dbus.done), 8'd0);
    rst = 1'b0;
    check("rst_lfsr", dut.lfsr_q, 8'hA5);

    // Bounce: 3-cycle low pulses never get through the debouncer
    for (int p = 0; p < 5; p++) begin
      dbus.btn_n = 1'b0;
      tick(3);
      check("bounce_rolling", 8'(dbus.rolling), 8'd0);
      dbus.btn_n = 1'b1;
      tick(3);
      check("bounce_rolling", 8'(dbus.rolling), 8'd0);
    end
    tick(6);
    check("bounce_outs", outs(), 8'h00);

    // Press: rolling rises exactly 7 cycles after btn_n falls
    dbus.btn_n = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      check("press_latency", 8'(dbus.rolling), 8'd0);
    end
    tick(1);                                         // E7: SPIN
    check("press_rolling", 8'(dbus.rolling), 8'd1);
    check("spin_start", 8'(dbus.value), 8'd0);

    // Spin: +1 every 3 cycles, wraps after 8 steps
    for (int s = 1; s <= 8; s++) begin
      tick(2);
      check("spin_hold", 8'(dbus.value), 8'((s - 1) % 8));
      tick(1);
      check("spin_step", 8'(dbus.value), 8'(s % 8));
      check("spin_done", 8'(dbus.done), 8'd0);
    end                                              // E31: value 0

    // Release: spin continues until the debounced fall (E37), TUMBLE at E38
    dbus.btn_n = 1'b1;
    tick(6);                                         // E37
    check("rel_value", 8'(dbus.value), 8'd2);
    check("rel_rolling", 8'(dbus.rolling), 8'd1);
    tick(1);                                         // E38: TUMBLE entry
    check("tum_entry", outs(), {3'b000, 1'b1, 1'b0, 3'd2});
    tick(2);                                         // E40
    check("tum_hold1", 8'(dbus.value), 8'd2);
    exp1 = m_lfsr[2:0];
    tick(1);                                         // E41: first step (3 cycles)
    check("tum_step1", outs(), {3'b000, 1'b1, 1'b0, exp1});
    tick(5);                                         // E46
    check("tum_hold2", outs(), {3'b000, 1'b1, 1'b0, exp1});
    exp2 = m_lfsr[2:0];
    tick(1);                                         // E47: settle (6 cycles)
    check("settle_value", 8'(dbus.value), 8'(exp2));
    check("settle_done", 8'(dbus.done), 8'd1);
    check("settle_rolling", 8'(dbus.rolling), 8'd0);
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check("idle_hold", outs(), {3'b000, 1'b0, 1'b0, exp2});
    end

    // Re-press during TUMBLE
    start      = exp2;
    dbus.btn_n = 1'b0;
    tick(7);                                         // G7: SPIN
    check("rp_spin", outs(), {3'b000, 1'b1, 1'b0, start});
    dbus.btn_n = 1'b1;
    tick(3);                                         // G10
    check("rp_step1", 8'(dbus.value), 8'(3'(start + 3'd1)));
    tick(1);                                         // G11
    dbus.btn_n = 1'b0;
    tick(2);                                         // G13
    check("rp_step2", 8'(dbus.value), 8'(3'(start + 3'd2)));
    tick(1);                                         // G14: TUMBLE
    check("rp_tumble", outs(), {3'b000, 1'b1, 1'b0, 3'(start + 3'd2)});
    tick(2);                                         // G16
    exp3 = m_lfsr[2:0];
    tick(1);                                         // G17: tumble step k=1
    check("rp_tstep", outs(), {3'b000, 1'b1, 1'b0, exp3});
    tick(1);                                         // G18: back to SPIN
    check("rp_respin", outs(), {3'b000, 1'b1, 1'b0, exp3});
    tick(2);                                         // G20
    check("rp_kept", outs(), {3'b000, 1'b1, 1'b0, exp3});
    tick(1);                                         // G21
    check("rp_inc", 8'(dbus.value), 8'(3'(exp3 + 3'd1)));
    dbus.btn_n = 1'b1;
    tick(2);                                         // G23
    check("rp_nodone", outs(), {3'b000, 1'b1, 1'b0, 3'(exp3 + 3'd1)});
    tick(4);                                         // G27
    check("rp_inc3", 8'(dbus.value), 8'(3'(exp3 + 3'd3)));
    tick(3);                                         // G30: mid-TUMBLE
    check("mt_rolling", outs(), {3'b000, 1'b1, 1'b0, 3'(exp3 + 3'd3)});
    check("mt_state", 8'(dut.state_q), 8'(TUMBLE));

    // Reset mid-TUMBLE
    rst = 1'b1;
    tick(1);                                         // G31
    rst = 1'b0;
    check("mr_outs", outs(), 8'h00);
    check("mr_state", 8'(dut.state_q), 8'(IDLE));
    check("mr_lfsr", dut.lfsr_q, 8'hA5);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("mr_quiet", outs(), 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
